// File: rtl/axi_pkg.sv
// Shared AXI3 constants and AR field types for the read-side bridge blocks.
package axi_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned LEN_W          = 8;
    localparam int unsigned SIZE_W         = 3;

    // Address width varies per instance, so the address is added by the user of this type.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } ar_ctrl_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester after the last winner, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= IDX_W'(N - 1);
        end else if (en && found) begin
            ptr <= grant_idx;
        end
    end

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant = '0;
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-port burst read front end: round-robin AR issue tagged by port index, R beats routed back by rid.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            p_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]      p_len,
    input  logic [NUM_PORTS*SIZE_W-1:0]     p_size,
    output logic [NUM_PORTS-1:0]            p_addr_ok,
    output logic [NUM_PORTS-1:0]            p_data_ok,
    output logic [DATA_WIDTH-1:0]           p_rdata,
    output logic                            p_rlast,
    output logic                            err_sticky,
    output logic [ID_WIDTH-1:0]             arid,
    output logic [ADDR_WIDTH-1:0]           araddr,
    output logic [7:0]                      arlen,
    output logic [2:0]                      arsize,
    output logic [1:0]                      arburst,
    output logic [1:0]                      arlock,
    output logic [3:0]                      arcache,
    output logic [2:0]                      arprot,
    output logic                            arvalid,
    input  logic                            arready,
    input  logic [ID_WIDTH-1:0]             rid,
    input  logic [DATA_WIDTH-1:0]           rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        ar_ctrl_t              ctrl;
    } ar_t;

    ar_t                  ar_q;
    ar_t                  ar_sel;
    logic [NUM_PORTS-1:0] busy;
    logic [NUM_PORTS-1:0] busy_n;
    logic [NUM_PORTS-1:0] eligible;
    logic [IDX_W-1:0]     g_idx;
    logic                 grant_en;
    logic                 any_grant;
    logic                 beat;
    logic                 rid_ok;
    logic                 beat_ok;

    assign eligible  = p_req & ~busy;
    assign grant_en  = ~arvalid | arready;
    assign any_grant = |p_addr_ok;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (eligible),
        .en        (grant_en),
        .grant     (p_addr_ok),
        .grant_idx (g_idx)
    );

    always_comb begin
        ar_sel = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (g_idx == IDX_W'(i)) begin
                ar_sel.addr      = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ar_sel.ctrl.len  = p_len[i*LEN_W +: LEN_W];
                ar_sel.ctrl.size = p_size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    assign beat    = rvalid & rready;
    assign rid_ok  = 32'(rid) < NUM_PORTS;
    assign beat_ok = beat & rid_ok;

    // Beats are steered with zero latency; busy is freed by rlast and re-armed by a grant.
    always_comb begin
        p_data_ok = '0;
        busy_n    = busy;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (beat_ok && 32'(rid) == i) begin
                p_data_ok[i] = 1'b1;
                if (rlast) begin
                    busy_n[i] = 1'b0;
                end
            end
        end
        busy_n = busy_n | p_addr_ok;
    end

    assign p_rdata = rdata;
    assign p_rlast = beat_ok & rlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_q       <= '0;
            arid       <= '0;
            arvalid    <= 1'b0;
            busy       <= '0;
            err_sticky <= 1'b0;
            rready     <= 1'b0;
        end else begin
            rready <= 1'b1;
            busy   <= busy_n;
            if (grant_en) begin
                arvalid <= any_grant;
                if (any_grant) begin
                    ar_q <= ar_sel;
                    arid <= ID_WIDTH'(g_idx);
                end
            end
            if (beat && (!rid_ok || rresp != AXI_RESP_OKAY)) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.ctrl.len;
    assign arsize  = ar_q.ctrl.size;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

endmodule
